tl_d_chan_queue: RTL and testbench

//  Parametrised TileLink D-channel (grant/ack) FIFO between a TL agent and its consumer.

---
 rtl/tl_pkg.sv | 34 +++
 rtl/tl_queue_ram.sv | 27 ++
 rtl/tl_d_chan_queue.sv | 113 +++++++++++
 tb/tb_tl_d_chan_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// TileLink D-channel shared types: beat layout and opcode encodings.
package tl_pkg;

  localparam int TL_SIZE_W   = 4;
  localparam int TL_SOURCE_W = 4;
  localparam int TL_SINK_W   = 4;
  localparam int TL_DATA_W   = 64;

  localparam logic [2:0] TL_D_OPCODE_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_OPCODE_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] TL_D_OPCODE_GRANT           = 3'd4;
  localparam logic [2:0] TL_D_OPCODE_GRANT_DATA      = 3'd5;
  localparam logic [2:0] TL_D_OPCODE_RELEASE_ACK     = 3'd6;

  // Field order here is the bit order used for every flattened D beat.
  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_SINK_W-1:0]   sink;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } tl_d_bits_t;

  localparam int TL_D_BITS_W = $bits(tl_d_bits_t);

  // Width of a flattened D beat for arbitrary field widths.
  function automatic int tl_d_bits_w(int size_w, int source_w, int sink_w, int data_w);
    return 3 + 2 + size_w + source_w + sink_w + 1 + data_w + 1;
  endfunction

endpackage

// File: rtl/tl_queue_ram.sv
// Queue storage: one write port, one asynchronous read port, no reset.
module tl_queue_ram #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                                  clock,
  input  logic                                  we,
  input  logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] waddr,
  input  logic [W-1:0]                          wdata,
  input  logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] raddr,
  output logic [W-1:0]                          rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Sized to the full address space so any index is legal; entries
  // at or beyond DEPTH are never addressed by the queue pointers.
  logic [W-1:0] mem [0:(1<<AW)-1];

  // Capture the beat at the write pointer.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tl_d_chan_queue.sv
// Parametrised TileLink D-channel FIFO with optional flow-through and pipe modes.
module tl_d_chan_queue
  import tl_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int SIZE_W   = 4,
  parameter int SOURCE_W = 4,
  parameter int SINK_W   = 4,
  parameter int DATA_W   = 64,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_enq_valid,
  output logic                         io_enq_ready,
  input  logic [2:0]                   io_enq_bits_opcode,
  input  logic [1:0]                   io_enq_bits_param,
  input  logic [SIZE_W-1:0]            io_enq_bits_size,
  input  logic [SOURCE_W-1:0]          io_enq_bits_source,
  input  logic [SINK_W-1:0]            io_enq_bits_sink,
  input  logic                         io_enq_bits_denied,
  input  logic [DATA_W-1:0]            io_enq_bits_data,
  input  logic                         io_enq_bits_corrupt,
  input  logic                         io_deq_ready,
  output logic                         io_deq_valid,
  output logic [2:0]                   io_deq_bits_opcode,
  output logic [1:0]                   io_deq_bits_param,
  output logic [SIZE_W-1:0]            io_deq_bits_size,
  output logic [SOURCE_W-1:0]          io_deq_bits_source,
  output logic [SINK_W-1:0]            io_deq_bits_sink,
  output logic                         io_deq_bits_denied,
  output logic [DATA_W-1:0]            io_deq_bits_data,
  output logic                         io_deq_bits_corrupt,
  output logic [$clog2(DEPTH+1)-1:0]   io_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = tl_d_bits_w(SIZE_W, SOURCE_W, SINK_W, DATA_W);

  logic [PTR_W-1:0] enq_ptr, deq_ptr;
  logic             maybe_full;
  logic             ptr_match, empty, full;
  logic             do_enq, do_deq, flow_thru, write_fire, pop_fire;
  logic [W-1:0]     enq_flat, ram_rdata, deq_flat;

  // Wrap at DEPTH-1 so non-power-of-two depths cycle correctly; a
  // single-entry queue keeps both pointers at zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) return '0;
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match &  maybe_full;

  assign io_enq_ready = ~full | ((PIPE != 0) & io_deq_ready);
  assign io_deq_valid = ~empty | ((FLOW != 0) & io_enq_valid);

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

  // A flow-through beat bypasses storage entirely.
  assign flow_thru  = (FLOW != 0) & empty & do_deq;
  assign write_fire = do_enq & ~flow_thru;
  assign pop_fire   = do_deq & ~flow_thru;

  assign enq_flat = {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
                     io_enq_bits_source, io_enq_bits_sink, io_enq_bits_denied,
                     io_enq_bits_data, io_enq_bits_corrupt};

  tl_queue_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clock (clock),
    .we    (write_fire),
    .waddr (enq_ptr),
    .wdata (enq_flat),
    .raddr (deq_ptr),
    .rdata (ram_rdata)
  );

  assign deq_flat = ((FLOW != 0) & empty) ? enq_flat : ram_rdata;

  assign {io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size,
          io_deq_bits_source, io_deq_bits_sink, io_deq_bits_denied,
          io_deq_bits_data, io_deq_bits_corrupt} = deq_flat;

  // Pointer and full-flag update; reset drops all held beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (write_fire) enq_ptr <= ptr_inc(enq_ptr);
      if (pop_fire)   deq_ptr <= ptr_inc(deq_ptr);
      if (write_fire != pop_fire) maybe_full <= write_fire;
    end
  end

  // Occupancy from pointer distance, modulo DEPTH, without overflow.
  always_comb begin
    io_count = '0;
    if (full)
      io_count = CW'(DEPTH);
    else if (enq_ptr >= deq_ptr)
      io_count = CW'(enq_ptr - deq_ptr);
    else
      io_count = CW'(DEPTH) - CW'(deq_ptr - enq_ptr);
  end

endmodule

// File: tb/tb_tl_d_chan_queue.sv
// Directed and scoreboard bench for tl_d_chan_queue over several configurations.
module tb_tl_d_chan_queue;
  import tl_pkg::*;

  localparam int N = 6;
  // 0: D2  1: D3  2: D2 PIPE  3: D2 FLOW  4: D1  5: D5
  localparam int DEP [N] = '{2, 3, 2, 2, 1, 5};
  localparam int FLW [N] = '{0, 0, 0, 1, 0, 0};
  localparam int PIP [N] = '{0, 0, 1, 0, 0, 0};

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid, deq_ready;
  logic [2:0]  opcode;
  logic [1:0]  param;
  logic [3:0]  size, source, sink;
  logic        denied, corrupt;
  logic [63:0] data;

  logic [N-1:0] e_rdy, d_vld, d_den, d_cor;
  logic [2:0]   d_op  [N];
  logic [1:0]   d_par [N];
  logic [3:0]   d_siz [N];
  logic [3:0]   d_src [N];
  logic [3:0]   d_snk [N];
  logic [63:0]  d_dat [N];
  logic [3:0]   cnt   [N];

  int errs = 0;
  int nchk = 0;

  logic [63:0] rm [N][8];
  int hd [N];
  int mc [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : gq
    localparam int CWG = $clog2(DEP[g]+1);
    logic [CWG-1:0] c;
    tl_d_chan_queue #(.DEPTH(DEP[g]), .FLOW(FLW[g]), .PIPE(PIP[g])) u_dut (
      .clock               (clock),
      .reset               (reset),
      .io_enq_valid        (enq_valid),
      .io_enq_ready        (e_rdy[g]),
      .io_enq_bits_opcode  (opcode),
      .io_enq_bits_param   (param),
      .io_enq_bits_size    (size),
      .io_enq_bits_source  (source),
      .io_enq_bits_sink    (sink),
      .io_enq_bits_denied  (denied),
      .io_enq_bits_data    (data),
      .io_enq_bits_corrupt (corrupt),
      .io_deq_ready        (deq_ready),
      .io_deq_valid        (d_vld[g]),
      .io_deq_bits_opcode  (d_op[g]),
      .io_deq_bits_param   (d_par[g]),
      .io_deq_bits_size    (d_siz[g]),
      .io_deq_bits_source  (d_src[g]),
      .io_deq_bits_sink    (d_snk[g]),
      .io_deq_bits_denied  (d_den[g]),
      .io_deq_bits_data    (d_dat[g]),
      .io_deq_bits_corrupt (d_cor[g]),
      .io_count            (c)
    );
    assign cnt[g] = 4'(c);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one posedge; return just after the following negedge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rst_all();
    reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; mc[i] = 0; end
  endtask

  initial begin
    opcode = 3'd0; param = 2'd0; size = 4'd0; source = 4'd0; sink = 4'd0;
    denied = 1'b0; corrupt = 1'b0; data = 64'd0;
    rst_all();

    // 1: reset state and single-beat latency on DEPTH=2
    #1;
    chk("t1_rst_enq_ready", e_rdy[0], 1);
    chk("t1_rst_deq_valid", d_vld[0], 0);
    chk("t1_rst_count", cnt[0], 0);
    enq_valid = 1'b1; opcode = TL_D_OPCODE_ACCESS_ACK_DATA; data = 64'hDEAD;
    cyc();
    enq_valid = 1'b0; #1;
    chk("t1_deq_valid", d_vld[0], 1);
    chk("t1_data", d_dat[0], 64'hDEAD);
    chk("t1_opcode", d_op[0], 1);
    chk("t1_count", cnt[0], 1);

    // 2: DEPTH=3 fill, drain in order, then reuse across the wrap
    rst_all();
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; data = 64'hA0 + 64'(i);
      cyc();
    end
    enq_valid = 1'b0; #1;
    chk("t2_full_enq_ready", e_rdy[1], 0);
    chk("t2_full_count", cnt[1], 3);
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_drain_data", d_dat[1], 64'hA0 + 64'(i));
      chk("t2_drain_count", cnt[1], 64'(3 - i));
      cyc();
    end
    #1;
    chk("t2_empty_count", cnt[1], 0);
    chk("t2_empty_valid", d_vld[1], 0);
    deq_ready = 1'b0; enq_valid = 1'b1; data = 64'hA3;
    cyc();
    enq_valid = 1'b0; #1;
    chk("t2_wrap_data", d_dat[1], 64'hA3);
    chk("t2_wrap_count", cnt[1], 1);

    // 3: full DEPTH=2, pipe vs non-pipe
    rst_all();
    enq_valid = 1'b1; data = 64'hB0; cyc();
    data = 64'hB1; cyc();
    data = 64'hB2; deq_ready = 1'b1; #1;
    chk("t3_pipe_enq_ready", e_rdy[2], 1);
    chk("t3_nopipe_enq_ready", e_rdy[0], 0);
    chk("t3_pipe_head", d_dat[2], 64'hB0);
    chk("t3_pipe_count_pre", cnt[2], 2);
    cyc();
    enq_valid = 1'b0; deq_ready = 1'b0; #1;
    chk("t3_pipe_count_post", cnt[2], 2);
    chk("t3_pipe_head_post", d_dat[2], 64'hB1);
    chk("t3_nopipe_count", cnt[0], 1);
    chk("t3_nopipe_head", d_dat[0], 64'hB1);
    deq_ready = 1'b1; #1;
    chk("t3_drain0", d_dat[2], 64'hB1);
    cyc(); #1;
    chk("t3_drain1", d_dat[2], 64'hB2);
    chk("t3_drain1_count", cnt[2], 1);
    cyc(); #1;
    chk("t3_drain_empty", cnt[2], 0);

    // 4: flow-through on empty queue
    rst_all();
    #1;
    chk("t4_rst_deq_valid", d_vld[3], 0);
    enq_valid = 1'b1; deq_ready = 1'b1; source = 4'd5; data = 64'hC0;
    param = 2'd2; size = 4'd3; sink = 4'd9; denied = 1'b1; corrupt = 1'b1;
    #1;
    chk("t4_flow_valid", d_vld[3], 1);
    chk("t4_flow_source", d_src[3], 5);
    chk("t4_flow_data", d_dat[3], 64'hC0);
    chk("t4_flow_misc", {d_par[3], d_siz[3], d_snk[3], d_den[3], d_cor[3]},
        {2'd2, 4'd3, 4'd9, 1'b1, 1'b1});
    chk("t4_flow_count", cnt[3], 0);
    cyc();
    enq_valid = 1'b0; param = 2'd0; size = 4'd0; sink = 4'd0; denied = 1'b0;
    corrupt = 1'b0; source = 4'd0; #1;
    chk("t4_after_count", cnt[3], 0);
    chk("t4_after_valid", d_vld[3], 0);

    // 5: steady enq+deq at count 1, then reset with two held
    rst_all();
    enq_valid = 1'b1; data = 64'hD0; cyc();
    for (int i = 1; i <= 10; i++) begin
      data = 64'hD0 + 64'(i); deq_ready = 1'b1; #1;
      chk("t5_stream_data", d_dat[0], 64'hD0 + 64'(i - 1));
      chk("t5_stream_count", cnt[0], 1);
      cyc();
    end
    enq_valid = 1'b0; deq_ready = 1'b0; #1;
    chk("t5_tail_data", d_dat[0], 64'hDA);
    chk("t5_tail_count", cnt[0], 1);
    enq_valid = 1'b1; data = 64'hDB; cyc();
    enq_valid = 1'b0; #1;
    chk("t5_two_count", cnt[0], 2);
    reset = 1'b1; cyc();
    reset = 1'b0; #1;
    chk("t5_reset_count", cnt[0], 0);
    chk("t5_reset_valid", d_vld[0], 0);

    // 6: random traffic against a per-instance ring scoreboard
    rst_all();
    for (int n = 0; n < 10000; n++) begin
      enq_valid = ($urandom_range(0, 99) < 60);
      deq_ready = ($urandom_range(0, 99) < 55);
      data = {$urandom, $urandom};
      #1;
      for (int i = 0; i < N; i++) begin
        logic fe, fd, fl;
        chk("t6_count", cnt[i], 64'(mc[i]));
        chk("t6_enq_ready", e_rdy[i], 64'((mc[i] < DEP[i]) || (PIP[i] != 0 && deq_ready)));
        chk("t6_deq_valid", d_vld[i], 64'((mc[i] > 0) || (FLW[i] != 0 && enq_valid)));
        fe = enq_valid & e_rdy[i];
        fd = d_vld[i] & deq_ready;
        fl = (mc[i] == 0) && fd;
        if (fd) chk("t6_data", d_dat[i], (mc[i] > 0) ? rm[i][hd[i]] : data);
        if (fd && mc[i] > 0) begin hd[i] = (hd[i] + 1) % 8; mc[i]--; end
        if (fe && !fl && mc[i] < 8) begin rm[i][(hd[i] + mc[i]) % 8] = data; mc[i]++; end
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
